// File: rtl/m_ext_pkg.sv
// m_ext_pkg: shared constants and enums for the RV32M/RV64M execute unit.
//   OPCODE_OP / FUNCT7_MEXT : decode values that qualify an M-extension op
//   m_op_e                  : funct3 operation encodings
//   m_state_e               : iterative unit FSM states
package m_ext_pkg;

  localparam logic [6:0] OPCODE_OP   = 7'b0110011;
  localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } m_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } m_state_e;

endpackage

// File: rtl/m_ext_decode.sv
// m_ext_decode: combinational funct3 decode for the M-extension unit.
//   funct3_i     : M-ext op select
//   is_div_o     : op uses the divider (DIV/DIVU/REM/REMU)
//   is_rem_o     : result is the remainder
//   rs1_signed_o : rs1 is treated as two's complement
//   rs2_signed_o : rs2 is treated as two's complement
//   high_half_o  : multiply returns the upper XLEN bits
module m_ext_decode
  import m_ext_pkg::*;
(
  input  logic [2:0] funct3_i,
  output logic       is_div_o,
  output logic       is_rem_o,
  output logic       rs1_signed_o,
  output logic       rs2_signed_o,
  output logic       high_half_o
);

  always_comb begin
    is_div_o     = 1'b0;
    is_rem_o     = 1'b0;
    rs1_signed_o = 1'b0;
    rs2_signed_o = 1'b0;
    high_half_o  = 1'b0;
    case (m_op_e'(funct3_i))
      OP_MUL:    ;
      OP_MULH:   begin rs1_signed_o = 1'b1; rs2_signed_o = 1'b1; high_half_o = 1'b1; end
      OP_MULHSU: begin rs1_signed_o = 1'b1; high_half_o = 1'b1; end
      OP_MULHU:  high_half_o = 1'b1;
      OP_DIV:    begin is_div_o = 1'b1; rs1_signed_o = 1'b1; rs2_signed_o = 1'b1; end
      OP_DIVU:   is_div_o = 1'b1;
      OP_REM:    begin is_div_o = 1'b1; is_rem_o = 1'b1; rs1_signed_o = 1'b1; rs2_signed_o = 1'b1; end
      OP_REMU:   begin is_div_o = 1'b1; is_rem_o = 1'b1; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/m_ext_unit.sv
// m_ext_unit: iterative RV32M/RV64M multiply/divide execute unit.
//   clk_i, rst_i (sync, active-high), flush_i (abort in-flight op)
//   valid_i/ready_o     : request handshake (opcode_i, funct3_i, funct7_i, rs1_i, rs2_i)
//   valid_o/ready_i     : result handshake (result_o)
//   busy_o              : op accepted and not yet consumed
// Optional: define M_EXT_EARLY_OUT_EN for 1-cycle zero-operand multiplies and
// small-dividend divides.
module m_ext_unit
  import m_ext_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [6:0]      opcode_i,
  input  logic [2:0]      funct3_i,
  input  logic [6:0]      funct7_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  m_state_e          state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  // Multiply: {accumulator, multiplier}. Divide: {remainder, dividend/quotient}.
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic              neg_q, neg_d;
  logic              high_q, high_d;
  logic              rem_q, rem_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic is_div, is_rem, rs1_signed, rs2_signed, high_half;

  m_ext_decode u_decode (
    .funct3_i     (funct3_i),
    .is_div_o     (is_div),
    .is_rem_o     (is_rem),
    .rs1_signed_o (rs1_signed),
    .rs2_signed_o (rs2_signed),
    .high_half_o  (high_half)
  );

  logic              accept, sign1, sign2;
  logic [XLEN-1:0]   mag1, mag2;
  logic              special;
  logic [XLEN-1:0]   special_res;
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] step_next, mul_full;
  logic [XLEN-1:0]   div_val, final_res;

  always_comb begin
    accept = valid_i && (state_q == S_IDLE) && !flush_i &&
             (opcode_i == OPCODE_OP) && (funct7_i == FUNCT7_MEXT);
    sign1  = rs1_signed && rs1_i[XLEN-1];
    sign2  = rs2_signed && rs2_i[XLEN-1];
    mag1   = sign1 ? -rs1_i : rs1_i;
    mag2   = sign2 ? -rs2_i : rs2_i;

    special     = 1'b0;
    special_res = '0;
    if (is_div && (rs2_i == '0)) begin
      special     = 1'b1;
      special_res = is_rem ? rs1_i : '1;
    end else if (is_div && rs1_signed && (rs1_i == MIN_INT) && (rs2_i == '1)) begin
      special     = 1'b1;
      special_res = is_rem ? '0 : MIN_INT;
    end
`ifdef M_EXT_EARLY_OUT_EN
    else if (!is_div && ((rs1_i == '0) || (rs2_i == '0))) begin
      special     = 1'b1;
      special_res = '0;
    end else if (is_div && (mag1 < mag2)) begin
      special     = 1'b1;
      special_res = is_rem ? rs1_i : '0;
    end
`endif

    // One shift-add multiply step / one restoring divide step.
    mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    div_sh   = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    div_diff = div_sh - {1'b0, mcand_q};
    if (state_q == S_MUL)
      step_next = {mul_sum, prod_q[XLEN-1:1]};
    else if (div_diff[XLEN])
      step_next = {div_sh[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
    else
      step_next = {div_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};

    mul_full = neg_q ? -step_next : step_next;
    div_val  = rem_q ? step_next[2*XLEN-1:XLEN] : step_next[XLEN-1:0];
    if (state_q == S_MUL)
      final_res = high_q ? mul_full[2*XLEN-1:XLEN] : mul_full[XLEN-1:0];
    else
      final_res = neg_q ? -div_val : div_val;

    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    neg_d    = neg_q;
    high_d   = high_q;
    rem_d    = rem_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          busy_d = 1'b1;
          if (special) begin
            state_d  = S_DONE;
            valid_d  = 1'b1;
            result_d = special_res;
          end else begin
            state_d = is_div ? S_DIV : S_MUL;
            cnt_d   = CW'(XLEN - 1);
            prod_d  = {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
            mcand_d = is_div ? mag2 : mag1;
            neg_d   = is_rem ? sign1 : (sign1 ^ sign2);
            high_d  = high_half;
            rem_d   = is_rem;
          end
        end
      end
      S_MUL, S_DIV: begin
        prod_d = step_next;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          valid_d  = 1'b1;
          result_d = final_res;
        end
      end
      S_DONE: begin
        if (ready_i) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush_i) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      neg_q    <= 1'b0;
      high_q   <= 1'b0;
      rem_q    <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      neg_q    <= neg_d;
      high_q   <= high_d;
      rem_q    <= rem_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      result_q <= result_d;
    end
  end

  assign ready_o  = (state_q == S_IDLE);
  assign valid_o  = valid_q;
  assign busy_o   = busy_q;
  assign result_o = result_q;

endmodule
